// File: rtl/operand_fetch_seq.sv
// rtl/operand_fetch_seq.sv - operand fetch sequencer feeding the barrel shifter/ALU stage.
// Optional write-back forwarding is enabled by defining OPFETCH_WB_FWD_EN.
module operand_fetch_seq #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Flush,
  input  logic [DATA_W-1:0]  IR_in,
  input  logic [DATA_W-1:0]  PC_in,
  input  logic               CPSR_C,
  input  logic               IR_valid,
  output logic               IR_ready,
  output logic               RF_rd_en,
  output logic [RADDR_W-1:0] RF_addr,
  input  logic [DATA_W-1:0]  RF_data,
  output logic [DATA_W-1:0]  Rn_out,
  output logic [DATA_W-1:0]  Rm_out,
  output logic [DATA_W-1:0]  Rs_out,
  output logic [DATA_W-1:0]  IR_out,
  output logic               SR29_out,
  output logic               Unsup,
  output logic               Op_valid,
`ifdef OPFETCH_WB_FWD_EN
  input  logic               WB_en,
  input  logic [RADDR_W-1:0] WB_addr,
  input  logic [DATA_W-1:0]  WB_data,
`endif
  input  logic               Op_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  localparam logic [RADDR_W-1:0] R15 = RADDR_W'(15);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  ir_q, ir_d, pc_q, pc_d;
  logic [DATA_W-1:0]  rn_q, rn_d, rm_q, rm_d, rs_q, rs_d;
  logic               c_q, c_d, unsup_q, unsup_d;
  logic [1:0]         n_q, n_d, k_q, k_d, pk_q, pk_d;
  logic               pend_q, pend_d;
`ifdef OPFETCH_WB_FWD_EN
  logic [2:0]         got_q, got_d;
`endif

  logic [RADDR_W-1:0] rn_a, rm_a, rs_a, iss_a, cap_a;
  logic [DATA_W-1:0]  pc_plus8, cap_val;
  logic [1:0]         new_n;
  logic               new_unsup, accept;

  // List slots are always a prefix of (Rn, Rm, Rs), so slot index selects the operand.
  assign rn_a     = RADDR_W'(ir_q[19:16]);
  assign rm_a     = RADDR_W'(ir_q[3:0]);
  assign rs_a     = RADDR_W'(ir_q[11:8]);
  assign pc_plus8 = pc_q + DATA_W'(8);

  always_comb begin
    case (k_q)
      2'd0:    iss_a = rn_a;
      2'd1:    iss_a = rm_a;
      default: iss_a = rs_a;
    endcase
    case (pk_q)
      2'd0:    cap_a = rn_a;
      2'd1:    cap_a = rm_a;
      default: cap_a = rs_a;
    endcase
  end

  always_comb begin
    cap_val = RF_data;
    if (cap_a == R15) cap_val = pc_plus8;
`ifdef OPFETCH_WB_FWD_EN
    else if (WB_en && (WB_addr == cap_a)) cap_val = WB_data;
`endif
  end

  always_comb begin
    new_n     = 2'd0;
    new_unsup = 1'b0;
    case (IR_in[27:25])
      3'b000:         new_n = IR_in[4] ? 2'd3 : 2'd2;
      3'b001, 3'b010: new_n = 2'd1;
      3'b011:         new_n = 2'd2;
      3'b101:         new_n = 2'd0;
      default:        new_unsup = 1'b1;
    endcase
  end

  assign IR_ready = (state_q == IDLE) || ((state_q == HOLD) && Op_ready);
  assign accept   = IR_valid && IR_ready && !Flush;
  assign Op_valid = (state_q == HOLD);
  // R15 slots are filled from the latched PC, so the port stays idle for them.
  assign RF_rd_en = (state_q == ISSUE) && (iss_a != R15);
  assign RF_addr  = RF_rd_en ? iss_a : '0;

  assign Rn_out   = rn_q;
  assign Rm_out   = rm_q;
  assign Rs_out   = rs_q;
  assign IR_out   = ir_q;
  assign SR29_out = c_q;
  assign Unsup    = unsup_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    c_d     = c_q;
    unsup_d = unsup_q;
    n_d     = n_q;
    k_d     = k_q;
    pk_d    = pk_q;
    pend_d  = 1'b0;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rs_d    = rs_q;
`ifdef OPFETCH_WB_FWD_EN
    got_d   = got_q;
    if ((state_q != IDLE) && WB_en && (WB_addr != R15)) begin
      if (got_q[0] && (WB_addr == rn_a)) rn_d = WB_data;
      if (got_q[1] && (WB_addr == rm_a)) rm_d = WB_data;
      if (got_q[2] && (WB_addr == rs_a)) rs_d = WB_data;
    end
`endif
    if (pend_q) begin
      case (pk_q)
        2'd0:    rn_d = cap_val;
        2'd1:    rm_d = cap_val;
        default: rs_d = cap_val;
      endcase
`ifdef OPFETCH_WB_FWD_EN
      case (pk_q)
        2'd0:    got_d[0] = 1'b1;
        2'd1:    got_d[1] = 1'b1;
        default: got_d[2] = 1'b1;
      endcase
`endif
    end

    case (state_q)
      IDLE: ;
      ISSUE: begin
        pend_d = 1'b1;
        pk_d   = k_q;
        if (k_q == n_q - 2'd1) state_d = DRAIN;
        else                   k_d     = k_q + 2'd1;
      end
      DRAIN: state_d = HOLD;
      HOLD:  if (Op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      ir_d    = IR_in;
      pc_d    = PC_in;
      c_d     = CPSR_C;
      unsup_d = new_unsup;
      n_d     = new_n;
      k_d     = 2'd0;
      rn_d    = '0;
      rm_d    = '0;
      rs_d    = '0;
`ifdef OPFETCH_WB_FWD_EN
      got_d   = 3'b000;
`endif
      state_d = (new_n != 2'd0) ? ISSUE : HOLD;
    end

    // Abandon: bundle contents freeze, the read in flight is dropped.
    if (Flush) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      rn_d    = rn_q;
      rm_d    = rm_q;
      rs_d    = rs_q;
`ifdef OPFETCH_WB_FWD_EN
      got_d   = got_q;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      c_q     <= 1'b0;
      unsup_q <= 1'b0;
      n_q     <= 2'd0;
      k_q     <= 2'd0;
      pk_q    <= 2'd0;
      pend_q  <= 1'b0;
      rn_q    <= '0;
      rm_q    <= '0;
      rs_q    <= '0;
`ifdef OPFETCH_WB_FWD_EN
      got_q   <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      c_q     <= c_d;
      unsup_q <= unsup_d;
      n_q     <= n_d;
      k_q     <= k_d;
      pk_q    <= pk_d;
      pend_q  <= pend_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rs_q    <= rs_d;
`ifdef OPFETCH_WB_FWD_EN
      got_q   <= got_d;
`endif
    end
  end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb/tb_operand_fetch_seq.sv - self-checking bench for operand_fetch_seq with a register-file model.
module tb_operand_fetch_seq;

  logic        Clk = 1'b0, Reset_n = 1'b0, Flush = 1'b0, CPSR_C = 1'b0;
  logic        IR_valid = 1'b0, Op_ready = 1'b0;
  logic [31:0] IR_in = '0, PC_in = '0, RF_data = '0;
  logic        IR_ready, RF_rd_en, SR29_out, Unsup, Op_valid;
  logic [3:0]  RF_addr;
  logic [31:0] Rn_out, Rm_out, Rs_out, IR_out;
`ifdef OPFETCH_WB_FWD_EN
  logic        WB_en = 1'b0;
  logic [3:0]  WB_addr = '0;
  logic [31:0] WB_data = '0;
`endif

  operand_fetch_seq #(.DATA_W(32), .RADDR_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .IR_in(IR_in), .PC_in(PC_in),
    .CPSR_C(CPSR_C), .IR_valid(IR_valid), .IR_ready(IR_ready), .RF_rd_en(RF_rd_en),
    .RF_addr(RF_addr), .RF_data(RF_data), .Rn_out(Rn_out), .Rm_out(Rm_out),
    .Rs_out(Rs_out), .IR_out(IR_out), .SR29_out(SR29_out), .Unsup(Unsup),
    .Op_valid(Op_valid),
`ifdef OPFETCH_WB_FWD_EN
    .WB_en(WB_en), .WB_addr(WB_addr), .WB_data(WB_data),
`endif
    .Op_ready(Op_ready)
  );

  always #5 Clk = ~Clk;

  int          total = 0, bad = 0;
  logic [31:0] rf [16];
  logic [31:0] hist = '0;
  int          rd_cnt = 0;

  // Synchronous-read register file plus a log of every port read.
  always @(posedge Clk) begin
    if (RF_rd_en) begin
      RF_data <= rf[RF_addr];
      hist    <= (hist << 5) | {27'd0, 1'b1, RF_addr};
      rd_cnt  <= rd_cnt + 1;
    end
  end

  logic [31:0] exp_op [3];
  logic [31:0] exp_pack, exp_ir;
  logic        exp_unsup, exp_c;
  int          exp_nrd, exp_lat, c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference: operand list from the instruction class, values from the RF model or PC+8.
  task automatic model(input logic [31:0] ir, input logic [31:0] pc, input logic c);
    logic [3:0] s [3];
    int n;
    s[0] = ir[19:16]; s[1] = ir[3:0]; s[2] = ir[11:8];
    case (ir[27:25])
      3'd0:       n = ir[4] ? 3 : 2;
      3'd1, 3'd2: n = 1;
      3'd3:       n = 2;
      default:    n = 0;
    endcase
    exp_unsup = (ir[27:25] == 3'd4) || (ir[27:25] == 3'd6) || (ir[27:25] == 3'd7);
    exp_ir = ir; exp_c = c; exp_nrd = 0; exp_pack = '0;
    for (int j = 0; j < 3; j++) begin
      exp_op[j] = '0;
      if (j < n) begin
        if (s[j] == 4'd15) exp_op[j] = pc + 32'd8;
        else begin
          exp_op[j] = rf[s[j]];
          exp_pack  = (exp_pack << 5) | {27'd0, 1'b1, s[j]};
          exp_nrd++;
        end
      end
    end
    exp_lat = (n == 0) ? 0 : n + 1;
  endtask

  task automatic check_bundle();
    logic [31:0] mask;
    mask = (32'd1 << (5 * exp_nrd)) - 32'd1;
    chk("op_valid", Op_valid, 1'b1);
    chk("rn", Rn_out, exp_op[0]);
    chk("rm", Rm_out, exp_op[1]);
    chk("rs", Rs_out, exp_op[2]);
    chk("ir_out", IR_out, exp_ir);
    chk("sr29", SR29_out, exp_c);
    chk("unsup", Unsup, exp_unsup);
    chk("nreads", rd_cnt - c0, exp_nrd);
    chk("raddrs", hist & mask, exp_pack);
  endtask

  // Called at a negedge; b2b offers the instruction on the handshake cycle of a held bundle.
  task automatic present(input logic [31:0] ir, input logic [31:0] pc, input logic c,
                         input logic b2b);
    int edges;
    model(ir, pc, c);
    IR_in = ir; PC_in = pc; CPSR_C = c; IR_valid = 1'b1; Op_ready = b2b;
    c0 = rd_cnt;
    #1 chk("ir_ready_acc", IR_ready, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    IR_valid = 1'b0; Op_ready = 1'b0;
    edges = 0;
    while (!Op_valid && edges < 12) begin
      @(negedge Clk);
      edges++;
    end
    chk("latency", edges, exp_lat);
    check_bundle();
  endtask

  task automatic hold(input int h);
    repeat (h) begin
      @(negedge Clk);
      chk("hold_valid", Op_valid, 1'b1);
      chk("hold_irready", IR_ready, 1'b0);
      chk("hold_rden", {RF_rd_en, RF_addr}, 5'd0);
      chk("hold_rn", Rn_out, exp_op[0]);
      chk("hold_rm", Rm_out, exp_op[1]);
      chk("hold_rs", Rs_out, exp_op[2]);
      chk("hold_ir", IR_out, exp_ir);
    end
  endtask

  task automatic release_bundle();
    Op_ready = 1'b1;
    #1 chk("rel_irready", IR_ready, 1'b1);
    @(negedge Clk);
    Op_ready = 1'b0;
    chk("rel_valid", Op_valid, 1'b0);
    chk("rel_idle", IR_ready, 1'b1);
  endtask

  task automatic check_reset();
    chk("rst_irready", IR_ready, 1'b1);
    chk("rst_valid", Op_valid, 1'b0);
    chk("rst_rden", {RF_rd_en, RF_addr}, 5'd0);
    chk("rst_ops", Rn_out | Rm_out | Rs_out, 32'd0);
    chk("rst_ir", IR_out, 32'd0);
    chk("rst_flags", {SR29_out, Unsup}, 2'd0);
  endtask

  initial begin
    logic [31:0] ir;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    #1 check_reset();
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;

    // ADD R2,R1,R1,ASR R3: reads 1,1,3 then DRAIN, bundle after 4 edges.
    rf[1] = 32'h8000_0000; rf[3] = 32'd4;
    present(32'hE081_2351, 32'h0000_1000, 1'b0, 1'b0);
    chk("shift_rn", Rn_out, 32'h8000_0000);
    chk("shift_rs", Rs_out, 32'd4);
    chk("shift_addrs", hist[14:0], {5'h11, 5'h11, 5'h13});
    hold(5);

    // Immediate form accepted on the handshake cycle of the held bundle.
    present(32'hE3A0_04FF, 32'h0000_2000, 1'b1, 1'b1);
    chk("imm_sr29", SR29_out, 1'b1);
    hold(1);
    release_bundle();

    present(32'hEA00_0010, 32'h0000_3000, 1'b0, 1'b0);
    chk("branch_reads", rd_cnt - c0, 0);
    release_bundle();

    present(32'hE1A0_000F, 32'h0000_0100, 1'b0, 1'b0);
    chk("pc_rm", Rm_out, 32'h0000_0108);
    release_bundle();

    // Flush in ISSUE.
    IR_in = 32'hE081_2351; IR_valid = 1'b1;
    @(negedge Clk);
    IR_valid = 1'b0;
    chk("fl_issue", RF_rd_en, 1'b1);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    chk("fl_rden", RF_rd_en, 1'b0);
    chk("fl_idle", IR_ready, 1'b1);
    repeat (4) begin
      @(negedge Clk);
      chk("fl_valid", Op_valid, 1'b0);
    end
    chk("fl_ir_kept", IR_out, 32'hE081_2351);

    // Flush beats a simultaneous accept.
    IR_in = 32'hE3A0_04FF; IR_valid = 1'b1; Flush = 1'b1;
    @(negedge Clk);
    IR_valid = 1'b0; Flush = 1'b0;
    chk("flacc_ir", IR_out, 32'hE081_2351);
    chk("flacc_rden", RF_rd_en, 1'b0);
    @(negedge Clk);
    chk("flacc_valid", Op_valid, 1'b0);

    // Asynchronous reset mid-ISSUE, then a normal fetch.
    IR_in = 32'hE081_2351; PC_in = 32'h40; CPSR_C = 1'b1; IR_valid = 1'b1;
    @(negedge Clk);
    IR_valid = 1'b0;
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    present(32'hE081_2351, 32'h0000_0040, 1'b1, 1'b0);
    release_bundle();

    // Random instructions, random hold lengths and back-to-back accepts.
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 16; r++) rf[r] = $urandom;
      ir = $urandom;
      if ($urandom_range(0, 3) == 0) ir[3:0] = 4'hF;
      if ($urandom_range(0, 5) == 0) ir[19:16] = 4'hF;
      if (i > 0 && $urandom_range(0, 1) == 0) release_bundle();
      present(ir, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
              Op_valid);
      hold($urandom_range(0, 2));
    end
    release_bundle();

`ifdef OPFETCH_WB_FWD_EN
    rf[1] = 32'h1234_5678;
    IR_in = 32'hE281_0000; IR_valid = 1'b1;
    @(negedge Clk);
    IR_valid = 1'b0;
    @(negedge Clk);
    WB_en = 1'b1; WB_addr = 4'd1; WB_data = 32'h55;
    @(negedge Clk);
    WB_en = 1'b0;
    chk("fwd_capture", Rn_out, 32'h55);
    release_bundle();
    present(32'hE281_0000, 32'h0, 1'b0, 1'b0);
    WB_en = 1'b1; WB_addr = 4'd1; WB_data = 32'h55;
    @(negedge Clk);
    WB_en = 1'b0;
    chk("fwd_hold", Rn_out, 32'h55);
    release_bundle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
